// File: rtl/layer_seq_pkg.sv
// Shared types and helpers for the inter-layer stream sequencer.
// Used by layer_stream_seq and layer_argmax.
package layer_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default neuron word width; downstream argmax consumers use word_t.
  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] word_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_argmax.sv
// Running signed max/index over a streamed frame.
// Ties keep the lowest index; word 0 reseeds the running max.
module layer_argmax
  import layer_seq_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int IDXW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 first,
  input  logic                 last,
  input  logic [IDXW-1:0]      idx,
  input  logic [dataWidth-1:0] data,
  output logic                 res_valid,
  output logic [IDXW-1:0]      res_idx
);

  logic signed [dataWidth-1:0] max_q;
  logic signed [dataWidth-1:0] word;
  logic [IDXW-1:0]             idx_q;
  logic [IDXW-1:0]             best;
  logic                        take;

  assign word = data;
  assign take = first || (word > max_q);
  assign best = take ? idx : idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q     <= '0;
      idx_q     <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
    end else begin
      res_valid <= valid && last;
      if (valid && take) begin
        max_q <= word;
        idx_q <= idx;
      end
      if (valid && last)
        res_idx <= best;
    end
  end

endmodule

// File: rtl/layer_stream_seq.sv
// Captures a parallel layer output and replays it as a word stream.
// Optional argmax tracking under LAYER_SEQ_ARGMAX_EN.
module layer_stream_seq
  import layer_seq_pkg::*;
#(
  parameter  int NN        = 10,
  parameter  int dataWidth = 16,
  localparam int IDXW      = idx_width(NN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    busy,
  output logic                    seq_err,
  output logic                    argmax_valid,
  output logic [IDXW-1:0]         argmax_idx
);

  localparam logic [IDXW-1:0] LAST = IDXW'(NN - 1);

  state_t                  state;
  state_t                  state_n;
  logic [IDXW-1:0]         cnt;
  logic [IDXW-1:0]         cnt_n;
  logic [NN*dataWidth-1:0] frame;
  logic [dataWidth-1:0]    data_n;
  logic                    capture;
  logic                    partial;
  logic                    last;
  logic                    accept;
  logic                    collide;

  always_comb begin
    capture = &i_valid;
    partial = (|i_valid) && !capture;
    last    = (state == SHIFT) && (cnt == LAST);
    accept  = capture && ((state == IDLE) || last);
    collide = capture && (state == SHIFT) && !last;
    state_n = state;
    cnt_n   = cnt;
    data_n  = o_data;
    // A capture on the last word chains the next frame with no bubble.
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      data_n  = i_data[0 +: dataWidth];
    end else begin
      unique case (state)
        IDLE: ;
        SHIFT: begin
          if (last) begin
            state_n = IDLE;
            cnt_n   = '0;
            data_n  = '0;
          end else begin
            cnt_n  = cnt + 1'b1;
            data_n = frame[int'(cnt_n)*dataWidth +: dataWidth];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      frame   <= '0;
      o_data  <= '0;
      seq_err <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      o_data <= data_n;
      if (accept)
        frame <= i_data;
      if (collide || partial)
        seq_err <= 1'b1;
    end
  end

  assign o_valid = (state == SHIFT);
  assign busy    = o_valid;

`ifdef LAYER_SEQ_ARGMAX_EN
  layer_argmax #(
    .dataWidth(dataWidth),
    .IDXW     (IDXW)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .valid    (o_valid),
    .first    (cnt == '0),
    .last     (cnt == LAST),
    .idx      (cnt),
    .data     (o_data),
    .res_valid(argmax_valid),
    .res_idx  (argmax_idx)
  );
`else
  assign argmax_valid = 1'b0;
  assign argmax_idx   = '0;
`endif

endmodule

// File: tb/tb_layer_stream_seq.sv
// Directed bench for layer_stream_seq (NN=10, 16-bit words).
// Argmax checks follow LAYER_SEQ_ARGMAX_EN.
module tb_layer_stream_seq;

  localparam int NN   = 10;
  localparam int W    = 16;
  localparam int IDXW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NN-1:0]     i_valid;
  logic [NN*W-1:0]   i_data;
  logic              o_valid;
  logic [W-1:0]      o_data;
  logic              busy;
  logic              seq_err;
  logic              argmax_valid;
  logic [IDXW-1:0]   argmax_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_stream_seq #(
    .NN       (NN),
    .dataWidth(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .busy        (busy),
    .seq_err     (seq_err),
    .argmax_valid(argmax_valid),
    .argmax_idx  (argmax_idx)
  );

  function automatic logic [NN*W-1:0] ramp(input int base, input int stp);
    logic [NN*W-1:0] r;
    r = '0;
    for (int k = 0; k < NN; k++)
      r[k*W +: W] = W'(base + stp*k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = '0;
    i_data = '0;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b exp 0", o_valid); end
    n_checks++;
    if (o_data !== '0) begin n_fail++; $display("FAIL reset_o_data got %0d exp 0", o_data); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq_err got %b exp 0", seq_err); end
    n_checks++;
    if (argmax_valid !== 1'b0) begin n_fail++; $display("FAIL reset_am_valid got %b exp 0", argmax_valid); end
    n_checks++;
    if (argmax_idx !== '0) begin n_fail++; $display("FAIL reset_am_idx got %0d exp 0", argmax_idx); end
  endtask

  task automatic test_single_frame();
    i_data = ramp(10, 10);
    i_valid = '1;
    for (int k = 0; k < NN; k++) begin
      step();
      if (k == 0) i_valid = '0;
      n_checks++;
      if (o_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL single_valid k=%0d got %b/%b exp 1/1", k, o_valid, busy);
      end
      n_checks++;
      if (o_data !== W'(10*(k+1))) begin
        n_fail++; $display("FAIL single_data k=%0d got %0d exp %0d", k, o_data, 10*(k+1));
      end
      n_checks++;
      if (argmax_valid !== 1'b0) begin
        n_fail++; $display("FAIL single_am_early k=%0d got %b exp 0", k, argmax_valid);
      end
    end
    step();
    n_checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end got %b/%b exp 0/0", o_valid, busy);
    end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL single_seq_err got %b exp 0", seq_err); end
`ifdef LAYER_SEQ_ARGMAX_EN
    n_checks++;
    if (argmax_valid !== 1'b1 || argmax_idx !== 4'd9) begin
      n_fail++; $display("FAIL single_am got %b/%0d exp 1/9", argmax_valid, argmax_idx);
    end
`else
    n_checks++;
    if (argmax_valid !== 1'b0 || argmax_idx !== 4'd0) begin
      n_fail++; $display("FAIL single_am_tied got %b/%0d exp 0/0", argmax_valid, argmax_idx);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int exp;
    i_data = ramp(10, 10);
    i_valid = '1;
    for (int k = 0; k < 2*NN; k++) begin
      step();
      if (k == 0) i_valid = '0;
      if (k == 9) begin
        i_data = ramp(200, 1);
        i_valid = '1;
      end
      if (k == 10) i_valid = '0;
      exp = (k < NN) ? 10*(k+1) : 200 + k - NN;
      n_checks++;
      if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid k=%0d got %b exp 1", k, o_valid); end
      n_checks++;
      if (o_data !== W'(exp)) begin
        n_fail++; $display("FAIL b2b_data k=%0d got %0d exp %0d", k, o_data, exp);
      end
`ifdef LAYER_SEQ_ARGMAX_EN
      n_checks++;
      if (argmax_valid !== (k == NN)) begin
        n_fail++; $display("FAIL b2b_am_pulse k=%0d got %b exp %b", k, argmax_valid, k == NN);
      end
`endif
    end
    step();
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", o_valid); end
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL b2b_seq_err got %b exp 0", seq_err); end
`ifdef LAYER_SEQ_ARGMAX_EN
    n_checks++;
    if (argmax_valid !== 1'b1 || argmax_idx !== 4'd9) begin
      n_fail++; $display("FAIL b2b_am got %b/%0d exp 1/9", argmax_valid, argmax_idx);
    end
`endif
  endtask

  task automatic test_argmax();
    int w [NN] = '{-5, 3, 7, 7, -100, 0, 2, 1, 6, -1};
    logic [NN*W-1:0] f;
    for (int k = 0; k < NN; k++) f[k*W +: W] = W'(w[k]);
    i_data = f;
    i_valid = '1;
    for (int k = 0; k < NN; k++) begin
      step();
      if (k == 0) i_valid = '0;
      n_checks++;
      if (o_data !== W'(w[k]) || o_valid !== 1'b1) begin
        n_fail++; $display("FAIL am_data k=%0d got %0d exp %0d", k, $signed(o_data), w[k]);
      end
      n_checks++;
      if (argmax_valid !== 1'b0) begin
        n_fail++; $display("FAIL am_early k=%0d got %b exp 0", k, argmax_valid);
      end
    end
    step();
`ifdef LAYER_SEQ_ARGMAX_EN
    n_checks++;
    if (argmax_valid !== 1'b1 || argmax_idx !== 4'd2) begin
      n_fail++; $display("FAIL am_result got %b/%0d exp 1/2", argmax_valid, argmax_idx);
    end
    step();
    n_checks++;
    if (argmax_valid !== 1'b0 || argmax_idx !== 4'd2) begin
      n_fail++; $display("FAIL am_hold got %b/%0d exp 0/2", argmax_valid, argmax_idx);
    end
`else
    n_checks++;
    if (argmax_valid !== 1'b0 || argmax_idx !== 4'd0) begin
      n_fail++; $display("FAIL am_tied got %b/%0d exp 0/0", argmax_valid, argmax_idx);
    end
`endif
  endtask

  task automatic test_partial();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (seq_err !== 1'b0) begin n_fail++; $display("FAIL part_pre got %b exp 0", seq_err); end
    i_data = ramp(1, 1);
    i_valid = 10'b0000000111;
    step();
    i_valid = '0;
    n_checks++;
    if (seq_err !== 1'b1) begin n_fail++; $display("FAIL part_err got %b exp 1", seq_err); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL part_stream k=%0d got %b/%b exp 0/0", k, o_valid, busy);
      end
      step();
    end
  endtask

  task automatic test_collision();
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_data = ramp(10, 10);
    i_valid = '1;
    for (int k = 0; k < NN; k++) begin
      step();
      if (k == 0) i_valid = '0;
      if (k == 4) begin
        i_data = ramp(200, 1);
        i_valid = '1;
      end
      if (k == 5) i_valid = '0;
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== W'(10*(k+1))) begin
        n_fail++; $display("FAIL coll_data k=%0d got %b/%0d exp 1/%0d", k, o_valid, o_data, 10*(k+1));
      end
      n_checks++;
      if (seq_err !== (k >= 5)) begin
        n_fail++; $display("FAIL coll_err k=%0d got %b exp %b", k, seq_err, k >= 5);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (o_valid !== 1'b0 || seq_err !== 1'b1) begin
        n_fail++; $display("FAIL coll_after k=%0d got %b/%b exp 0/1", k, o_valid, seq_err);
      end
    end
  endtask

  task automatic test_midframe_reset();
    i_data = ramp(10, 10);
    i_valid = '1;
    for (int k = 0; k <= 6; k++) begin
      step();
      if (k == 0) i_valid = '0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0 || o_data !== '0) begin
      n_fail++; $display("FAIL mid_rst got %b/%b/%0d exp 0/0/0", o_valid, busy, o_data);
    end
    n_checks++;
    if (seq_err !== 1'b0 || argmax_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_flags got %b/%b exp 0/0", seq_err, argmax_valid);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      n_checks++;
      if (o_valid !== 1'b0 || argmax_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_quiet k=%0d got %b/%b exp 0/0", k, o_valid, argmax_valid);
      end
    end
    i_data = ramp(30, 1);
    i_valid = '1;
    step();
    i_valid = '0;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== W'(30)) begin
      n_fail++; $display("FAIL mid_restart0 got %b/%0d exp 1/30", o_valid, o_data);
    end
    step();
    n_checks++;
    if (o_data !== W'(31)) begin
      n_fail++; $display("FAIL mid_restart1 got %0d exp 31", o_data);
    end
    for (int k = 0; k < NN; k++) step();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_argmax();
    test_partial();
    test_collision();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
